hamming_frame_decoder: RTL and testbench

HAMMING_FRAME_DECODER -- requirements
Module: hamming_frame_decoder

---
 rtl/hamming_frame_decoder_pkg.sv | 58 +++++
 rtl/hamming_frame_decoder_syndrome.sv | 16 +
 rtl/hamming_frame_decoder.sv | 101 ++++++++++
 tb/tb_hamming_frame_decoder.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_frame_decoder_pkg.sv
// Shared Hamming(21,16) definitions: codeword geometry, parity positions,
// position/data-bit mapping and the matching encoder.
package hamming_frame_decoder_pkg;

  localparam int CODE_W     = 21;
  localparam int DATA_W     = 16;
  localparam int NUM_PARITY = 5;

  localparam logic [4:0] PARITY_POS [NUM_PARITY] = '{5'd1, 5'd2, 5'd4, 5'd8, 5'd16};

  function automatic logic is_parity(input logic [4:0] pos);
    for (int k = 0; k < NUM_PARITY; k++) begin
      if (pos == PARITY_POS[k]) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Bit index into the codeword vector (position minus one) of data bit bit_idx.
  function automatic logic [4:0] data_idx(input int bit_idx);
    int n;
    n = 0;
    data_idx = '0;
    for (int p = 1; p <= CODE_W; p++) begin
      if (!is_parity(5'(p))) begin
        if (n == bit_idx) data_idx = 5'(p - 1);
        n++;
      end
    end
  endfunction

  function automatic logic [DATA_W-1:0] extract_data(input logic [CODE_W-1:0] code);
    logic [DATA_W-1:0] data;
    data = '0;
    for (int i = 0; i < DATA_W; i++) begin
      data[i] = code[data_idx(i)];
    end
    return data;
  endfunction

  function automatic logic [CODE_W-1:0] hamming_encode(input logic [DATA_W-1:0] data);
    logic [CODE_W-1:0] code;
    logic              par;
    code = '0;
    for (int i = 0; i < DATA_W; i++) begin
      code[data_idx(i)] = data[i];
    end
    // Each parity bit covers every position whose index shares its single set bit.
    for (int k = 0; k < NUM_PARITY; k++) begin
      par = 1'b0;
      for (int p = 1; p <= CODE_W; p++) begin
        if ((5'(p) & PARITY_POS[k]) != 5'd0) par = par ^ code[5'(p - 1)];
      end
      code[PARITY_POS[k] - 5'd1] = par;
    end
    return code;
  endfunction

endpackage

// File: rtl/hamming_frame_decoder_syndrome.sv
// Combinational Hamming(21,16) syndrome: XOR of the positions of all set bits.
module hamming_syndrome
  import hamming_frame_decoder_pkg::*;
(
  input  logic [20:0] code,
  output logic [4:0]  syndrome
);

  always_comb begin
    syndrome = '0;
    for (int i = 0; i < CODE_W; i++) begin
      if (code[i]) syndrome = syndrome ^ 5'(i + 1);
    end
  end

endmodule

// File: rtl/hamming_frame_decoder.sv
// Two-stage Hamming(21,16) decoder with valid/ready flow control and
// saturating corrected/uncorrectable word counters.
module hamming_frame_decoder
  import hamming_frame_decoder_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [20:0]      code_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [15:0]      data_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             corr_flag,
  output logic             uncorr_flag,
  input  logic             clear_counts,
  output logic [CNT_W-1:0] corr_count,
  output logic [CNT_W-1:0] uncorr_count
);

  // Handshake: a word moves on a clock edge only when valid and ready are both
  // high; a producer holds valid and its payload steady until that edge.

  logic [4:0]  in_syn;
  logic        s1_valid;
  logic [20:0] s1_code;
  logic [4:0]  s1_syn;
  logic        s2_load;
  logic        out_fire;
  logic [20:0] fixed_code;
  logic [15:0] fixed_data;
  logic        fix_corr;
  logic        fix_uncorr;

  hamming_syndrome u_syndrome (
    .code     (code_in),
    .syndrome (in_syn)
  );

  assign out_fire = out_valid & out_ready;
  assign s2_load  = s1_valid & (~out_valid | out_ready);
  assign in_ready = ~reset & (~s1_valid | ~out_valid | out_ready);

  always_comb begin
    fixed_code = s1_code;
    fix_corr   = 1'b0;
    fix_uncorr = 1'b0;
    if (s1_syn > 5'd21) begin
      fix_uncorr = 1'b1;
    end else if (s1_syn != 5'd0) begin
      fixed_code[s1_syn - 5'd1] = ~s1_code[s1_syn - 5'd1];
      fix_corr = 1'b1;
    end
    fixed_data = extract_data(fixed_code);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid     <= 1'b0;
      s1_code      <= '0;
      s1_syn       <= '0;
      out_valid    <= 1'b0;
      data_out     <= '0;
      corr_flag    <= 1'b0;
      uncorr_flag  <= 1'b0;
      corr_count   <= '0;
      uncorr_count <= '0;
    end else begin
      if (in_valid && in_ready) begin
        s1_valid <= 1'b1;
        s1_code  <= code_in;
        s1_syn   <= in_syn;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end

      if (s2_load) begin
        out_valid   <= 1'b1;
        data_out    <= fixed_data;
        corr_flag   <= fix_corr;
        uncorr_flag <= fix_uncorr;
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end

      // Clear wins over a same-cycle increment; counts stick at all-ones.
      if (clear_counts) begin
        corr_count   <= '0;
        uncorr_count <= '0;
      end else begin
        if (out_fire && corr_flag && corr_count != '1)
          corr_count <= corr_count + 1'b1;
        if (out_fire && uncorr_flag && uncorr_count != '1)
          uncorr_count <= uncorr_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hamming_frame_decoder.sv
// Self-checking bench for hamming_frame_decoder: directed cases plus random
// traffic against a position-level Hamming reference model.
module tb_hamming_frame_decoder;
  import hamming_frame_decoder_pkg::*;

  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             reset;
  logic [20:0]      code_in;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      data_out;
  logic             out_valid;
  logic             out_ready;
  logic             corr_flag;
  logic             uncorr_flag;
  logic             clear_counts;
  logic [CNT_W-1:0] corr_count;
  logic [CNT_W-1:0] uncorr_count;

  typedef struct packed {
    logic [15:0] d;
    logic        c;
    logic        u;
  } exp_t;

  exp_t exp_q[$];
  int   m_corr, m_uncorr;
  int   checks, errors;
  bit   last_in_fire;
  bit   ovr_valid;
  exp_t ovr_exp;

  hamming_frame_decoder #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .code_in      (code_in),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .data_out     (data_out),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .corr_flag    (corr_flag),
    .uncorr_flag  (uncorr_flag),
    .clear_counts (clear_counts),
    .corr_count   (corr_count),
    .uncorr_count (uncorr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic exp_t ref_decode(input logic [20:0] c);
    exp_t e;
    int   s, n;
    s = 0;
    for (int p = 1; p <= 21; p++) if (c[p-1]) s = s ^ p;
    e.c = 1'b0;
    e.u = 1'b0;
    if (s >= 1 && s <= 21) begin
      c[s-1] = ~c[s-1];
      e.c = 1'b1;
    end else if (s > 21) begin
      e.u = 1'b1;
    end
    e.d = '0;
    n = 0;
    for (int p = 1; p <= 21; p++) begin
      if ((p & (p - 1)) != 0) begin
        e.d[n] = c[p-1];
        n++;
      end
    end
    return e;
  endfunction

  function automatic logic [20:0] ref_encode(input logic [15:0] d);
    logic [20:0] c;
    int          n;
    bit          par;
    c = '0;
    n = 0;
    for (int p = 1; p <= 21; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p-1] = d[n];
        n++;
      end
    end
    for (int k = 0; k < 5; k++) begin
      par = 1'b0;
      for (int p = 1; p <= 21; p++) if ((p & (1 << k)) != 0) par = par ^ c[p-1];
      c[(1 << k) - 1] = par;
    end
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock: sample handshakes before the edge, update the model, check after.
  task automatic tick();
    bit          in_fire, out_fire, hold;
    logic [15:0] hd;
    logic        hc, hu;
    exp_t        e;
    #1;
    chk("in_ready", in_ready, reset ? 0 : ((exp_q.size() < 2 || out_ready) ? 1 : 0));
    in_fire  = in_valid && in_ready && !reset;
    out_fire = out_valid && out_ready && !reset;
    hold     = out_valid && !out_ready && !reset;
    hd = data_out;
    hc = corr_flag;
    hu = uncorr_flag;
    if (out_fire) begin
      chk("output_expected", (exp_q.size() > 0) ? 1 : 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("data_out", data_out, e.d);
        chk("corr_flag", corr_flag, e.c);
        chk("uncorr_flag", uncorr_flag, e.u);
      end
      if (hc && m_corr < CNT_MAX) m_corr++;
      if (hu && m_uncorr < CNT_MAX) m_uncorr++;
    end
    if (clear_counts) begin
      m_corr   = 0;
      m_uncorr = 0;
    end
    if (in_fire) exp_q.push_back(ovr_valid ? ovr_exp : ref_decode(code_in));
    last_in_fire = in_fire;
    @(posedge clk);
    if (reset) begin
      exp_q.delete();
      m_corr   = 0;
      m_uncorr = 0;
    end
    @(negedge clk);
    if (hold) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", data_out, hd);
      chk("hold_corr", corr_flag, hc);
      chk("hold_uncorr", uncorr_flag, hu);
    end
    if (reset) chk("reset_out_valid", out_valid, 0);
    chk("corr_count", corr_count, m_corr);
    chk("uncorr_count", uncorr_count, m_uncorr);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    logic [20:0] cw;
    logic [15:0] rt_data [2];
    int          accepts, sent, mode, b1, b2;
    checks = 0; errors = 0; m_corr = 0; m_uncorr = 0;
    ovr_valid = 1'b0; ovr_exp = '0; last_in_fire = 1'b0;
    reset = 1'b1; code_in = '0; in_valid = 1'b0; out_ready = 1'b0; clear_counts = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_data_out", data_out, 0);
    chk("rst_corr_flag", corr_flag, 0);
    chk("rst_uncorr_flag", uncorr_flag, 0);
    reset = 1'b0;

    // Clean word with latency check
    code_in = 21'h000007; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    chk("lat_cycle1_valid", out_valid, 0);
    in_valid = 1'b0;
    tick();
    chk("lat_cycle2_valid", out_valid, 1);
    chk("clean_data", data_out, 16'h0001);
    chk("clean_corr", corr_flag, 0);
    chk("clean_uncorr", uncorr_flag, 0);
    drain();

    // Single-bit error at position 5
    code_in = 21'h000010; in_valid = 1'b1;
    tick();
    drain();
    chk("single_corr_count", corr_count, 1);

    // Uncorrectable, syndrome 22
    code_in = 21'h008020; in_valid = 1'b1;
    tick();
    drain();
    chk("uncorr_count_1", uncorr_count, 1);
    chk("uncorr_corr_unchanged", corr_count, 1);

    // Back-pressure: four words, out_ready low for five cycles
    out_ready = 1'b0; accepts = 0; sent = 0;
    for (int cyc = 0; cyc < 30 && sent < 4; cyc++) begin
      if (cyc == 5) out_ready = 1'b1;
      in_valid = 1'b1;
      code_in  = ref_encode(16'($urandom)) ^ (21'd1 << $urandom_range(0, 20));
      tick();
      if (last_in_fire) sent++;
      if (cyc < 5 && last_in_fire) accepts++;
    end
    chk("bp_accepts_while_stalled", accepts, 2);
    chk("bp_all_sent", sent, 4);
    drain();

    // Saturation: 300 corrected words
    code_in = 21'h000010; in_valid = 1'b1; out_ready = 1'b1;
    repeat (300) tick();
    drain();
    chk("sat_corr_count", corr_count, CNT_MAX);

    // Clear in the same cycle as an increment
    code_in = 21'h000010; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    chk("clr_word_ready", out_valid, 1);
    out_ready = 1'b1; clear_counts = 1'b1;
    tick();
    clear_counts = 1'b0;
    chk("clr_corr_count", corr_count, 0);
    drain();

    // Round trip through the package encoder with every single-bit flip
    rt_data[0] = 16'd12345;
    rt_data[1] = 16'd10101;
    for (int w = 0; w < 2; w++) begin
      chk("encoder", hamming_encode(rt_data[w]), ref_encode(rt_data[w]));
      ovr_valid = 1'b1;
      ovr_exp   = '{d: rt_data[w], c: 1'b1, u: 1'b0};
      for (int b = 0; b < 21; b++) begin
        code_in  = hamming_encode(rt_data[w]) ^ (21'd1 << b);
        in_valid = 1'b1;
        out_ready = ($urandom_range(0, 3) != 0);
        tick();
        while (!last_in_fire) begin
          out_ready = 1'b1;
          tick();
        end
      end
      drain();
      ovr_valid = 1'b0;
    end

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      mode = $urandom_range(0, 3);
      cw   = ref_encode(16'($urandom));
      b1   = $urandom_range(0, 20);
      b2   = $urandom_range(0, 20);
      if (mode == 1) cw = cw ^ (21'd1 << b1);
      if (mode == 2) cw = cw ^ (21'd1 << b1) ^ (21'd1 << b2);
      if (mode == 3) cw = 21'($urandom);
      if (!in_valid || last_in_fire) code_in = cw;
      in_valid     = (in_valid && !last_in_fire) ? 1'b1 : ($urandom_range(0, 9) < 7);
      out_ready    = ($urandom_range(0, 9) < 7);
      clear_counts = ($urandom_range(0, 19) == 0);
      tick();
    end
    clear_counts = 1'b0;
    drain();

    // Reset mid-stream discards in-flight words
    out_ready = 1'b0; in_valid = 1'b1;
    code_in = ref_encode(16'hBEEF);
    tick();
    code_in = ref_encode(16'h1234) ^ 21'h000100;
    tick();
    chk("mid_pipe_full", exp_q.size(), 2);
    in_valid = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("post_reset_no_output", out_valid, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
